// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction fetch and data access.
// Each access runs grant (IDLE) -> MEM_LATENCY cycles of ACCESS -> one RESP cycle; one access is
// in flight at a time. Data requests beat fetch requests by default.
// Build option: define ARB_ROUND_ROBIN_EN to alternate between requesters on simultaneous requests.
module mem_port_arbiter #(
  parameter int unsigned AW          = 64,
  parameter int unsigned DW          = 64,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  // Instruction fetch requester (read-only)
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  // Data requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // Memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CntW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic {OwnIf, OwnData} owner_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            we_q;
  owner_e          owner_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic            can_grant;
  logic            pick_data;
  logic            grant_any;
  logic            last_access;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_q;

  // Arbitration: on a conflict, favour whoever was not granted last.
  always_comb begin
    pick_data = d_req & (~if_req | (last_owner_q == OwnIf));
  end

  // Remember the most recent winner, lone requesters included.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_owner_q <= OwnIf;
    end else if (d_gnt) begin
      last_owner_q <= OwnData;
    end else if (if_gnt) begin
      last_owner_q <= OwnIf;
    end
  end
`else
  // Arbitration: data always beats fetch.
  always_comb begin
    pick_data = d_req;
  end
`endif

  // Grants are combinational in IDLE; gated by Reset so nothing is granted while it is held.
  always_comb begin
    can_grant = (state_q == StIdle) & ~Reset;
    d_gnt     = can_grant & pick_data;
    if_gnt    = can_grant & if_req & ~pick_data;
    grant_any = d_gnt | if_gnt;
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          state_d = StAccess;
          cnt_d   = CntInit;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and latency counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the winning request on its grant edge; fetches never write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= OwnIf;
    end else if (d_gnt) begin
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
      we_q    <= d_we;
      owner_q <= OwnData;
    end else if (if_gnt) begin
      addr_q  <= if_addr;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= OwnIf;
    end
  end

  // Final ACCESS cycle: memory data is sampled here.
  always_comb begin
    last_access = (state_q == StAccess) && (cnt_q == '0);
  end

  // Capture read data into the owner's holding register; writes leave d_rdata alone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (last_access) begin
      if (owner_q == OwnIf) begin
        if_rdata_q <= mem_rdata;
      end else if (!we_q) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs decoded from registered state, so Reset clears them immediately.
  always_comb begin
    busy      = (state_q != StIdle);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    // Write strobe only in the first ACCESS cycle so multi-cycle accesses write once.
    mem_wr    = (state_q == StAccess) && we_q && (cnt_q == CntInit);
    if_rvalid = (state_q == StResp) && (owner_q == OwnIf);
    d_rvalid  = (state_q == StResp) && (owner_q == OwnData);
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule
